// File: rtl/grid_tracer_if.sv
// rtl/grid_tracer_if.sv - signal bundle between the grid tracer and its VGA/sensor environment
// Inputs to the tracer:  clear, row[8:0], col[9:0], ir_in[N-1:0], R, S, G, H
// Outputs of the tracer: color_in_box, box_color[7:0], traced[N-1:0],
//                        traced_count[clog2(N+1)-1:0], new_trace,
//                        trace_idx[clog2(N)-1:0], all_traced
// master = environment side (drives inputs), slave = tracer side.
interface grid_tracer_if #(
  parameter int GRID_ROWS = 4,
  parameter int GRID_COLS = 4
);
  localparam int N     = GRID_ROWS * GRID_COLS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic             clear;
  logic [8:0]       row;
  logic [9:0]       col;
  logic [N-1:0]     ir_in;
  logic             R;
  logic             S;
  logic             G;
  logic             H;
  logic             color_in_box;
  logic [7:0]       box_color;
  logic [N-1:0]     traced;
  logic [CNT_W-1:0] traced_count;
  logic             new_trace;
  logic [IDX_W-1:0] trace_idx;
  logic             all_traced;

  modport master (
    output clear, row, col, ir_in, R, S, G, H,
    input  color_in_box, box_color, traced, traced_count, new_trace, trace_idx, all_traced
  );

  modport slave (
    input  clear, row, col, ir_in, R, S, G, H,
    output color_in_box, box_color, traced, traced_count, new_trace, trace_idx, all_traced
  );
endinterface

// File: rtl/grid_tracer.sv
// rtl/grid_tracer.sv - grid box mapper, IR debouncer, traced-box memory and progress FSM
// Ports:
//   clk     system clock
//   resetn  synchronous active-low reset
//   bus     grid_tracer_if.slave: clear, pixel row/col, ir_in, house selects in;
//           highlight flag, house colour, traced flags/count, new_trace/trace_idx,
//           all_traced out
module grid_tracer #(
  parameter int GRID_ROWS  = 4,
  parameter int GRID_COLS  = 4,
  parameter int BOX_SIZE   = 100,
  parameter int ORIGIN_ROW = 40,
  parameter int ORIGIN_COL = 120,
  parameter int DEBOUNCE   = 4
) (
  input  logic          clk,
  input  logic          resetn,
  grid_tracer_if.slave  bus
);
  localparam int N     = GRID_ROWS * GRID_COLS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int DW    = $clog2(DEBOUNCE + 1);

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TRACING  = 2'd1,
    S_COMPLETE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DW-1:0]    deb_q [N];
  logic [N-1:0]     traced_q;
  logic [N-1:0]     traced_d;
  logic [N-1:0]     qual;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             new_trace_q;
  logic             hl_q;
  logic             hl_d;
  logic [7:0]       color_q;
  logic [7:0]       color_d;
  logic             all_traced;
  logic             frozen;
  logic             any_qual;
  logic             all_set;

  // ---------------- pixel mapping ----------------
  logic [10:0]          row11;
  logic [10:0]          col11;
  logic [GRID_ROWS-1:0] in_row;
  logic [GRID_COLS-1:0] in_col;
  logic [N-1:0]         in_box;
  logic                 in_grid;

  assign row11 = {2'b00, bus.row};
  assign col11 = {1'b0, bus.col};

  // A single wrapping subtract-and-compare checks both bounds: pixels below
  // the lower bound wrap to a large value and fail the < BOX_SIZE test.
  for (genvar gr = 0; gr < GRID_ROWS; gr++) begin : g_row
    localparam logic [10:0] LO = 11'(ORIGIN_ROW + gr * BOX_SIZE);
    logic [10:0] off;
    assign off        = row11 - LO;
    assign in_row[gr] = off < 11'(BOX_SIZE);
  end

  for (genvar gc = 0; gc < GRID_COLS; gc++) begin : g_col
    localparam logic [10:0] LO = 11'(ORIGIN_COL + gc * BOX_SIZE);
    logic [10:0] off;
    assign off        = col11 - LO;
    assign in_col[gc] = off < 11'(BOX_SIZE);
  end

  for (genvar br = 0; br < GRID_ROWS; br++) begin : g_box_r
    for (genvar bc = 0; bc < GRID_COLS; bc++) begin : g_box_c
      assign in_box[br * GRID_COLS + bc] = in_row[br] & in_col[bc];
    end
  end

  assign in_grid = (|in_row) & (|in_col);

  // ---------------- qualification ----------------
  assign frozen = (state_q == S_COMPLETE);

  always_comb begin
    qual = '0;
    for (int k = 0; k < N; k++) begin
      qual[k] = bus.ir_in[k] && (deb_q[k] == DEB_LAST) && !traced_q[k] && !frozen;
    end
  end

  assign traced_d = traced_q | qual;
  assign any_qual = |qual;
  assign all_set  = &traced_d;

  always_comb begin
    count_d = '0;
    for (int k = 0; k < N; k++) begin
      count_d = count_d + CNT_W'(traced_d[k]);
    end
  end

  // Scan downward so the lowest qualifying index wins.
  always_comb begin
    idx_d = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (qual[k]) idx_d = IDX_W'(k);
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (any_qual) state_d = all_set ? S_COMPLETE : S_TRACING;
      S_TRACING:  if (all_set)  state_d = S_COMPLETE;
      S_COMPLETE: state_d = S_COMPLETE;
      default:    state_d = S_IDLE;
    endcase
    if (bus.clear) state_d = S_IDLE;
  end

  always_comb begin
    all_traced = (state_q == S_COMPLETE);
  end

  // ---------------- datapath registers ----------------
  always_comb begin
    if (frozen) hl_d = in_grid;
    else        hl_d = |(in_box & (traced_q | bus.ir_in));
  end

  always_ff @(posedge clk) begin
    if (!resetn || bus.clear) begin
      for (int k = 0; k < N; k++) deb_q[k] <= '0;
      traced_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      new_trace_q <= 1'b0;
      hl_q        <= 1'b0;
    end else begin
      if (!frozen) begin
        for (int k = 0; k < N; k++) begin
          if (!bus.ir_in[k])           deb_q[k] <= '0;
          else if (deb_q[k] != DEB_MAX) deb_q[k] <= deb_q[k] + DW'(1);
        end
      end
      traced_q    <= traced_d;
      count_q     <= count_d;
      idx_q       <= any_qual ? idx_d : '0;
      new_trace_q <= any_qual;
      hl_q        <= hl_d;
    end
  end

  // ---------------- house colour ----------------
  always_comb begin
    if (bus.R)      color_d = 8'h99;
    else if (bus.S) color_d = 8'h16;
    else if (bus.G) color_d = 8'h49;
    else if (bus.H) color_d = 8'hdc;
    else            color_d = 8'h00;
  end

  // Colour keeps tracking the house selects through a game clear.
  always_ff @(posedge clk) begin
    if (!resetn) color_q <= 8'h00;
    else         color_q <= color_d;
  end

  assign bus.color_in_box = hl_q;
  assign bus.box_color    = color_q;
  assign bus.traced       = traced_q;
  assign bus.traced_count = count_q;
  assign bus.new_trace    = new_trace_q;
  assign bus.trace_idx    = idx_q;
  assign bus.all_traced   = all_traced;
endmodule
